// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache types for the memory-port arbiter: grant state, captured
// request record, default widths and the starvation counter step.
package cache_mem_arbiter_pkg;

    // Defaults track the dcache address and line widths.
    localparam int unsigned CACHE_ADDR_W = 32;
    localparam int unsigned CACHE_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } type_arb_state_e;

    // Request held for the lifetime of one memory transaction.
    typedef struct packed {
        logic                    wr;
        logic [CACHE_ADDR_W-1:0] addr;
        logic [CACHE_LINE_W-1:0] wdata;
    } type_arb_req_s;

    // Counter value after a dcache grant: counts up while the icache is
    // left waiting, saturating at the limit, and restarts otherwise.
    function automatic logic [2:0] starve_step(input logic [2:0] cnt,
                                               input logic       icache_waiting,
                                               input logic [2:0] limit);
        logic [2:0] nxt;
        if (!icache_waiting) begin
            nxt = 3'd0;
        end else if (cnt >= limit) begin
            nxt = limit;
        end else begin
            nxt = cnt + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbiter for the single data-memory port shared by the instruction cache
// and the write-back data cache. The dcache has priority; a saturating
// counter forces an icache grant after STARVE_MAX dcache grants taken
// while the icache was waiting. All outputs come straight from registers.
// ADDR_W/LINE_W are expected to match the package defaults.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = CACHE_ADDR_W,
    parameter int unsigned LINE_W     = CACHE_LINE_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache2arb_req_i,
    input  logic [ADDR_W-1:0] icache2arb_addr_i,
    output logic              arb2icache_ack_o,
    output logic [LINE_W-1:0] arb2icache_data_o,
    input  logic              dcache2arb_req_i,
    input  logic              dcache2arb_wr_i,
    input  logic [ADDR_W-1:0] dcache2arb_addr_i,
    input  logic [LINE_W-1:0] dcache2arb_wdata_i,
    input  logic              dcache2arb_kill_i,
    output logic              arb2dcache_ack_o,
    output logic [LINE_W-1:0] arb2dcache_data_o,
    output logic              arb2mem_req_o,
    output logic              arb2mem_wr_o,
    output logic [ADDR_W-1:0] arb2mem_addr_o,
    output logic [LINE_W-1:0] arb2mem_wdata_o,
    output logic              arb2mem_kill_o,
    input  logic              mem2arb_ack_i,
    input  logic [LINE_W-1:0] mem2arb_data_i
);

    localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

    type_arb_state_e   state_r;
    type_arb_state_e   state_s;
    type_arb_req_s     cap_r;
    type_arb_req_s     cap_s;
    logic [2:0]        starve_cnt_r;
    logic [2:0]        starve_cnt_s;
    logic              mem_req_r;
    logic              mem_req_s;
    logic              mem_kill_r;
    logic              mem_kill_s;
    logic              iack_r;
    logic              iack_s;
    logic              dack_r;
    logic              dack_s;
    logic              idata_ld_s;
    logic              ddata_ld_s;
    logic [LINE_W-1:0] idata_r;
    logic [LINE_W-1:0] ddata_r;
    logic              i_want_s;
    logic              d_want_s;

    // A requester whose ack is showing this cycle still holds req; ignore it
    // so the finished transaction is not granted a second time.
    assign i_want_s = icache2arb_req_i & ~iack_r;
    assign d_want_s = dcache2arb_req_i & ~dack_r;

    // Next-state, capture and pulse decode for the grant FSM.
    always_comb begin
        state_s      = state_r;
        cap_s        = cap_r;
        starve_cnt_s = starve_cnt_r;
        mem_req_s    = 1'b0;
        mem_kill_s   = 1'b0;
        iack_s       = 1'b0;
        dack_s       = 1'b0;
        idata_ld_s   = 1'b0;
        ddata_ld_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (i_want_s && (!d_want_s || (starve_cnt_r == STARVE_LIMIT))) begin
                    state_s      = ARB_GNT_I;
                    cap_s.wr     = 1'b0;
                    cap_s.addr   = CACHE_ADDR_W'(icache2arb_addr_i);
                    cap_s.wdata  = '0;
                    starve_cnt_s = 3'd0;
                    mem_req_s    = 1'b1;
                end else if (d_want_s) begin
                    state_s      = ARB_GNT_D;
                    cap_s.wr     = dcache2arb_wr_i;
                    cap_s.addr   = CACHE_ADDR_W'(dcache2arb_addr_i);
                    cap_s.wdata  = CACHE_LINE_W'(dcache2arb_wdata_i);
                    starve_cnt_s = starve_step(starve_cnt_r, i_want_s, STARVE_LIMIT);
                    mem_req_s    = 1'b1;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_GNT_I: begin
                if (mem2arb_ack_i) begin
                    state_s    = ARB_IDLE;
                    iack_s     = 1'b1;
                    idata_ld_s = 1'b1;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            ARB_GNT_D: begin
                // Kill beats a simultaneous memory ack; the returned line is dropped.
                if (dcache2arb_kill_i) begin
                    state_s    = ARB_IDLE;
                    mem_kill_s = 1'b1;
                end else if (mem2arb_ack_i) begin
                    state_s    = ARB_IDLE;
                    dack_s     = 1'b1;
                    ddata_ld_s = 1'b1;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    // FSM state and the registered control pulses seen by memory and caches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ARB_IDLE;
            mem_req_r  <= 1'b0;
            mem_kill_r <= 1'b0;
            iack_r     <= 1'b0;
            dack_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mem_req_r  <= mem_req_s;
            mem_kill_r <= mem_kill_s;
            iack_r     <= iack_s;
            dack_r     <= dack_s;
        end
    end

    // Captured request and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r        <= '0;
            starve_cnt_r <= 3'd0;
        end else begin
            cap_r        <= cap_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Per-requester return data, loaded on the owner's memory ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idata_r <= '0;
            ddata_r <= '0;
        end else begin
            if (idata_ld_s) begin
                idata_r <= mem2arb_data_i;
            end
            if (ddata_ld_s) begin
                ddata_r <= mem2arb_data_i;
            end
        end
    end

    assign arb2mem_req_o     = mem_req_r;
    assign arb2mem_kill_o    = mem_kill_r;
    assign arb2mem_wr_o      = cap_r.wr;
    assign arb2mem_addr_o    = ADDR_W'(cap_r.addr);
    assign arb2mem_wdata_o   = LINE_W'(cap_r.wdata);
    assign arb2icache_ack_o  = iack_r;
    assign arb2icache_data_o = idata_r;
    assign arb2dcache_ack_o  = dack_r;
    assign arb2dcache_data_o = ddata_r;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single data-memory port between the instruction cache and the write-back data cache. Requests are serialized through a registered grant FSM. The data cache has fixed priority, with a starvation guard for the instruction cache. Data-cache kills are forwarded to memory, and the killed transaction is dropped cleanly. The block sits between the two cache tops and the memory interface.

## Interface

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width (read and write data)
- STARVE_MAX, 4, consecutive dcache grants allowed while icache waits (1..7)

Ports:
- clk  in  1  clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- icache2arb_req_i  in  1  icache line-fill request, held until ack
- icache2arb_addr_i  in  ADDR_W  icache fill address
- arb2icache_ack_o  out  1  one-cycle completion pulse
- arb2icache_data_o  out  LINE_W  fill data, valid with ack
- dcache2arb_req_i  in  1  dcache request, held until ack or kill
- dcache2arb_wr_i  in  1  1 = writeback, 0 = fill
- dcache2arb_addr_i  in  ADDR_W  dcache address
- dcache2arb_wdata_i  in  LINE_W  writeback data
- dcache2arb_kill_i  in  1  abort current dcache transaction
- arb2dcache_ack_o  out  1  one-cycle completion pulse
- arb2dcache_data_o  out  LINE_W  fill data, valid with ack
- arb2mem_req_o  out  1  memory request
- arb2mem_wr_o  out  1  memory write enable
- arb2mem_addr_o  out  ADDR_W  memory address
- arb2mem_wdata_o  out  LINE_W  memory write data
- arb2mem_kill_o  out  1  one-cycle abort pulse to memory
- mem2arb_ack_i  in  1  memory completion
- mem2arb_data_i  in  LINE_W  memory read data, valid with ack

## Operation

- FSM states: IDLE, GNT_I (icache owns memory), GNT_D (dcache owns memory).
- IDLE grant choice:
  - Only dcache requests: GNT_D.
  - Only icache requests: GNT_I.
  - Both request and starve_cnt == STARVE_MAX: GNT_I.
  - Both request otherwise: GNT_D.
- On grant, the requester's addr/wr/wdata are captured into registers. Memory outputs are driven only from these registers and stay stable for the whole transaction. arb2mem_wr_o is 0 for icache grants.
- GNT_x on mem2arb_ack_i:
  - Capture mem2arb_data_i into the owner's data register.
  - Pulse the owner's ack next cycle.
  - Return to IDLE.
- Ack masking: in the cycle an ack pulse is high, that requester's req is ignored by IDLE arbitration. This prevents a stale regrant.
- Kill:
  - dcache2arb_kill_i in GNT_D: next cycle arb2mem_req_o = 0, arb2mem_kill_o pulses once, no dcache ack, state goes to IDLE.
  - Kill in the same cycle as mem2arb_ack_i: kill wins and the data is discarded.
  - Kill in IDLE or GNT_I: ignored.
- starve_cnt (3-bit):
  - Increments on each dcache grant made while icache2arb_req_i is high.
  - Clears on any icache grant, and on a dcache grant made while icache is not requesting.
  - Saturates at STARVE_MAX.
- dcache2arb_wr_i = 1 acks without returning meaningful data. The data register is still loaded.

## Timing

- Reset values: all outputs 0, state IDLE, starve_cnt 0, capture registers 0.
- Request sampled in IDLE at cycle t: arb2mem_req_o = 1 from t+1.
- arb2mem_req_o stays high until mem2arb_ack_i is sampled high, or until the cycle after a kill.
- mem2arb_ack_i at cycle m: arb2mem_req_o = 0 at m+1, owner ack = 1 at m+1 for exactly one cycle, data valid at m+1.
- Fastest round trip: a request at t with memory ack at t+1 gives requester ack at t+2. Earliest next grant is at t+2, with memory request at t+3.
- Memory ack outside GNT_x: ignored.
- Async reset mid-transaction: request is dropped immediately, no ack, no kill pulse is issued.

## Structure

- Shared cache package holds:
  - state enum type_arb_state_e
  - request capture struct type_arb_req_s (wr, addr, wdata)
  - ADDR_W/LINE_W defaults, aligned with the existing dcache defines
- No sub-module. The starvation counter is inline; a single FSM plus registers is natural.

## Test plan

- Single icache fill, addr 0x0000_1000, memory ack 3 cycles after req, data 0xA5..A5 -> one-cycle arb2icache_ack_o, data matches, arb2mem_wr_o = 0 throughout.
- Simultaneous icache and dcache requests, starve_cnt = 0 -> dcache granted first. Icache is granted in IDLE right after the dcache ack; no double grant to the dcache.
- Dcache requests back-to-back with icache held high, STARVE_MAX = 4 -> exactly 4 dcache grants, then an icache grant, then starve_cnt = 0.
- Dcache writeback addr 0x8000_0040, kill asserted 2 cycles into the grant -> one-cycle arb2mem_kill_o, arb2mem_req_o drops, no arb2dcache_ack_o, pending icache granted next.
- Kill and mem2arb_ack_i in the same cycle -> no dcache ack; kill pulse still issued.
- rst_n low mid GNT_D -> all outputs 0 immediately. After release, an icache-only request is granted normally.
